// File: rtl/sigma_delta_adc_multi.sv
// rtl/sigma_delta_adc_multi.sv - multi-channel 1-bit sigma-delta ADC with shared CIC comb and tagged output FIFO
//
// Purpose: NUM_CHANNELS first-order sigma-delta front ends. Each channel has its own
// CIC integrator chain. One comb section is time-shared across the channels, and
// samples are queued with their channel index.
// Optional feature macro: SD_ADC_CHANNEL_MASK_EN adds the channel_enable input.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   adc_lvds_pin[N]   comparator results (input above integrator voltage)
//   adc_fb_pin[N]     registered feedback to the external integrators
//   channel_enable[N] (SD_ADC_CHANNEL_MASK_EN only) per-channel FIFO write enable
//   out_data          decimated unsigned sample, full scale OVERSAMPLE_RATE**CIC_STAGES
//   out_channel       channel index of out_data
//   out_valid/ready   output handshake
//   overrun           one-cycle pulse per dropped sample
module sigma_delta_adc_multi #(
  parameter int NUM_CHANNELS    = 4,
  parameter int OVERSAMPLE_RATE = 256,
  parameter int CIC_STAGES      = 2,
  parameter int ADC_BITLEN      = 24,
  parameter int FIFO_DEPTH      = 8,
  localparam int CH_W = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_CHANNELS-1:0] adc_lvds_pin,
  output logic [NUM_CHANNELS-1:0] adc_fb_pin,
`ifdef SD_ADC_CHANNEL_MASK_EN
  input  logic [NUM_CHANNELS-1:0] channel_enable,
`endif
  output logic [ADC_BITLEN-1:0]   out_data,
  output logic [CH_W-1:0]         out_channel,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    overrun
);

  localparam int LOG_R  = $clog2(OVERSAMPLE_RATE);
  localparam int W      = CIC_STAGES * LOG_R + 1;
  localparam int AW     = $clog2(FIFO_DEPTH);
  localparam int WARM_W = $clog2(CIC_STAGES + 1);

  if (ADC_BITLEN < W) begin : g_bad_bitlen
    $error("ADC_BITLEN is narrower than the CIC word width");
  end
  if (NUM_CHANNELS < 1 || NUM_CHANNELS > OVERSAMPLE_RATE) begin : g_bad_channels
    $error("NUM_CHANNELS must be in 1..OVERSAMPLE_RATE");
  end

  typedef enum logic {S_IDLE, S_COMB} state_t;

  logic [LOG_R-1:0]        r_dec_cnt;
  logic [W-1:0]            r_integ [NUM_CHANNELS][CIC_STAGES];
  logic [W-1:0]            r_snap  [NUM_CHANNELS];
  logic [W-1:0]            r_dly   [NUM_CHANNELS][CIC_STAGES];
  state_t                  r_state;
  logic [CH_W-1:0]         r_idx;
  logic [WARM_W-1:0]       r_warm;
  logic [ADC_BITLEN+CH_W-1:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0]           r_wr_ptr, r_rd_ptr;
  logic [AW:0]             r_count;

  logic                    w_snap, w_warm_done, w_wr_req, w_wr, w_rd, w_full;
  logic [NUM_CHANNELS-1:0] w_chan_en;
  logic [W-1:0]            w_stage [CIC_STAGES];
  logic [W-1:0]            w_acc;
  logic [ADC_BITLEN+CH_W-1:0] w_wdata, w_head;
  logic [AW:0]             w_count_nxt;
  logic [AW-1:0]           w_rd_ptr_nxt;

  assign w_snap      = &r_dec_cnt;
  assign w_warm_done = (r_warm == WARM_W'(CIC_STAGES));

  // Front end: feedback register doubles as the CIC input bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      adc_fb_pin <= '0;
      r_dec_cnt  <= '0;
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        r_snap[c] <= '0;
        for (int k = 0; k < CIC_STAGES; k++) r_integ[c][k] <= '0;
      end
    end else begin
      adc_fb_pin <= adc_lvds_pin;
      r_dec_cnt  <= r_dec_cnt + LOG_R'(1);
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        // Modulo-2^W wrap is intended; the comb differences undo it.
        r_integ[c][0] <= r_integ[c][0] + W'(adc_fb_pin[c]);
        for (int k = 1; k < CIC_STAGES; k++)
          r_integ[c][k] <= r_integ[c][k] + r_integ[c][k-1];
        if (w_snap) r_snap[c] <= r_integ[c][CIC_STAGES-1];
      end
    end
  end

`ifdef SD_ADC_CHANNEL_MASK_EN
  logic [NUM_CHANNELS-1:0] r_chan_en;
  always_ff @(posedge clk) begin
    if (rst) r_chan_en <= '0;
    else if (w_snap) r_chan_en <= channel_enable;
  end
  assign w_chan_en = r_chan_en;
`else
  assign w_chan_en = '1;
`endif

  // All comb stages of the channel selected by r_idx, in one cycle.
  always_comb begin
    w_acc = r_snap[r_idx];
    for (int k = 0; k < CIC_STAGES; k++) begin
      w_stage[k] = w_acc;
      w_acc      = w_acc - r_dly[r_idx][k];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
      r_warm  <= '0;
      for (int c = 0; c < NUM_CHANNELS; c++)
        for (int k = 0; k < CIC_STAGES; k++) r_dly[c][k] <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_snap) begin
            r_state <= S_COMB;
            r_idx   <= '0;
          end
        end
        S_COMB: begin
          for (int k = 0; k < CIC_STAGES; k++) r_dly[r_idx][k] <= w_stage[k];
          if (r_idx == CH_W'(NUM_CHANNELS - 1)) begin
            r_state <= S_IDLE;
            if (!w_warm_done) r_warm <= r_warm + WARM_W'(1);
          end else begin
            r_idx <= r_idx + CH_W'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign w_wr_req = (r_state == S_COMB) && w_warm_done && w_chan_en[r_idx];
  assign w_rd     = out_valid && out_ready;
  assign w_full   = (r_count == (AW+1)'(FIFO_DEPTH));
  // A read in the same cycle frees the slot, so a full FIFO still accepts.
  assign w_wr     = w_wr_req && (!w_full || w_rd);
  assign w_wdata  = {r_idx, ADC_BITLEN'(w_acc)};

  // Next head: the entry being written when it lands in the head slot.
  always_comb begin
    w_count_nxt  = r_count + (AW+1)'(w_wr) - (AW+1)'(w_rd);
    w_rd_ptr_nxt = r_rd_ptr + AW'(w_rd);
    if (w_wr && (w_rd_ptr_nxt == r_wr_ptr)) w_head = w_wdata;
    else                                     w_head = r_mem[w_rd_ptr_nxt];
  end

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr_ptr] <= w_wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      out_valid   <= 1'b0;
      out_data    <= '0;
      out_channel <= '0;
      overrun     <= 1'b0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + AW'(1);
      r_rd_ptr  <= w_rd_ptr_nxt;
      r_count   <= w_count_nxt;
      out_valid <= (w_count_nxt != '0);
      if (w_count_nxt != '0) {out_channel, out_data} <= w_head;
      overrun   <= w_wr_req && !w_wr;
    end
  end

endmodule

// File: tb/tb_sigma_delta_adc_multi.sv
// tb/tb_sigma_delta_adc_multi.sv - directed self-checking bench for sigma_delta_adc_multi
module tb_sigma_delta_adc_multi;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  lvds_base = 4'h0;
  logic [3:0]  tog_mask  = 4'h0;
  logic        tog = 1'b0;
  logic [3:0]  lvds;
  logic [3:0]  fb;
  logic [23:0] out_data;
  logic [1:0]  out_channel;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic        overrun;
`ifdef SD_ADC_CHANNEL_MASK_EN
  logic [3:0]  ch_en = 4'hF;
`endif

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int n_ovr = 0;
  int q_ch[$];
  int q_dat[$];
  int q_cyc[$];

  localparam int FS   = 65536;
  localparam int HALF = 32768;

  assign lvds = lvds_base ^ (tog_mask & {4{tog}});

  sigma_delta_adc_multi #(
    .NUM_CHANNELS(4), .OVERSAMPLE_RATE(256), .CIC_STAGES(2),
    .ADC_BITLEN(24), .FIFO_DEPTH(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .adc_lvds_pin(lvds),
    .adc_fb_pin(fb),
`ifdef SD_ADC_CHANNEL_MASK_EN
    .channel_enable(ch_en),
`endif
    .out_data(out_data),
    .out_channel(out_channel),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .overrun(overrun)
  );

  always #5 clk = ~clk;

  // Alternating pattern source, changes away from the sampling edge.
  always @(negedge clk) tog = ~tog;

  // Cycle index since the last reset edge; equals the decimation counter phase.
  always @(posedge clk) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      q_ch.push_back(int'(out_channel));
      q_dat.push_back(int'(out_data));
      q_cyc.push_back(cyc);
    end
    if (overrun) n_ovr = n_ovr + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_samp(input string tag, input int i, input int ch, input int dat);
    if (i < q_ch.size()) begin
      chk({tag, "_ch"}, q_ch[i], ch);
      chk({tag, "_data"}, q_dat[i], dat);
    end else begin
      chk({tag, "_missing"}, q_ch.size(), i + 1);
    end
  endtask

  task automatic go_cyc(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    q_ch.delete();
    q_dat.delete();
    q_cyc.delete();
    n_ovr = 0;
  endtask

  initial begin
    // All-ones input, warm-up, latency and full scale.
    lvds_base = 4'hF;
    do_reset();
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0);
    chk("rst_channel", out_channel, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_fb", fb, 0);
    go_cyc(768);
    chk("warmup_no_samples", q_ch.size(), 0);
    go_cyc(774);
    chk("a_count_f2", q_ch.size(), 4);
    if (q_cyc.size() > 0) chk("a_latency_ch0", q_cyc[0], 769);
    else chk("a_latency_missing", q_cyc.size(), 1);
    for (int i = 0; i < 4; i++) chk_samp("a_f2", i, i, FS);
    go_cyc(1030);
    chk("a_count_f3", q_ch.size(), 8);
    for (int i = 4; i < 8; i++) chk_samp("a_f3", i, i - 4, FS);
    chk("a_no_overrun", n_ovr, 0);

    // Distinct patterns: ch0 low, ch1 alternating, ch2 high, ch3 low.
    lvds_base = 4'b0100;
    tog_mask  = 4'b0010;
    do_reset();
    go_cyc(774);
    chk("b_count", q_ch.size(), 4);
    chk_samp("b_ch0_zero", 0, 0, 0);
    chk_samp("b_ch1_half", 1, 1, HALF);
    chk_samp("b_ch2_full", 2, 2, FS);
    chk_samp("b_ch3_zero", 3, 3, 0);
    chk("b_fb_track", fb[3:2], 2'b01);

    // Stall three written frames: two stored, third dropped.
    lvds_base = 4'hF;
    tog_mask  = 4'h0;
    out_ready = 1'b0;
    do_reset();
    go_cyc(800);
    chk("c_head_valid", out_valid, 1);
    chk("c_head_ch", out_channel, 0);
    chk("c_head_data", out_data, FS);
    go_cyc(1290);
    chk("c_overruns", n_ovr, 4);
    chk("c_hold_valid", out_valid, 1);
    chk("c_hold_ch", out_channel, 0);
    chk("c_hold_data", out_data, FS);
    chk("c_no_reads", q_ch.size(), 0);
    out_ready = 1'b1;
    go_cyc(1300);
    chk("c_drain_count", q_ch.size(), 8);
    for (int i = 0; i < 8; i++) chk_samp("c_drain", i, i % 4, FS);
    chk("c_empty_after", out_valid, 0);

    // Full FIFO with reads during the comb writes: nothing dropped.
    out_ready = 1'b0;
    do_reset();
    go_cyc(1280);
    out_ready = 1'b1;
    go_cyc(1284);
    out_ready = 1'b0;
    chk("d_overrun_none", n_ovr, 0);
    chk("d_reads_in_comb", q_ch.size(), 4);
    go_cyc(1290);
    out_ready = 1'b1;
    go_cyc(1300);
    chk("d_total_count", q_ch.size(), 12);
    for (int i = 0; i < 12; i++) chk_samp("d_order", i, i % 4, FS);
    chk("d_overrun_end", n_ovr, 0);
    chk("d_empty_after", out_valid, 0);

    // Reset in the middle of a comb sweep.
    do_reset();
    go_cyc(769);
    chk("e_valid_before", out_valid, 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("e_valid_cleared", out_valid, 0);
    chk("e_cyc_restart", cyc, 0);
    rst = 1'b0;
    q_ch.delete();
    q_dat.delete();
    q_cyc.delete();
    go_cyc(3);
    chk("e_fifo_empty", out_valid, 0);
    go_cyc(768);
    chk("e_warmup_again", q_ch.size(), 0);
    go_cyc(774);
    chk("e_count", q_ch.size(), 4);
    if (q_cyc.size() > 0) chk("e_first_cycle", q_cyc[0], 769);
    else chk("e_first_missing", q_cyc.size(), 1);
    for (int i = 0; i < 4; i++) chk_samp("e_f2", i, i, FS);

`ifdef SD_ADC_CHANNEL_MASK_EN
    // Channel mask: only 0 and 2, then all channels without new warm-up.
    ch_en = 4'b0101;
    do_reset();
    go_cyc(780);
    chk("m_count_masked", q_ch.size(), 2);
    chk_samp("m_ch0", 0, 0, FS);
    chk_samp("m_ch2", 1, 2, FS);
    go_cyc(800);
    ch_en = 4'b1111;
    go_cyc(1036);
    chk("m_count_all", q_ch.size(), 6);
    for (int i = 2; i < 6; i++) chk_samp("m_all", i, i - 2, FS);
    chk("m_no_overrun", n_ovr, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
